// File: rtl/fluxo_dados_genius_param.sv
// Parametrised sequence-memory game datapath: counters, sequence RAM,
// button register, play-edge detector, validator and timeout counter.
// Optional build macro: TIMEOUT_EN (enables the saturating timeout counter).
module fluxo_dados_genius_param #(
  parameter int W       = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 3000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          zeraE,
  input  logic          contaE,
  input  logic          zeraL,
  input  logic          contaL,
  input  logic          zeraR,
  input  logic          registraR,
  input  logic          escreveM,
  input  logic          contaT,
  input  logic [W-1:0]  botoes,
  output logic          fimE,
  output logic          fimL,
  output logic          enderecoIgualLimite,
  output logic          enderecoMenorLimite,
  output logic          igual,
  output logic          jogada_feita,
  output logic          jogada_valida,
  output logic          timeout,
  output logic [$clog2(DEPTH)-1:0] db_endereco,
  output logic [$clog2(DEPTH)-1:0] db_limite,
  output logic [W-1:0]  db_memoria,
  output logic [W-1:0]  db_jogada,
  output logic          db_tem_jogada
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] endereco;
  logic [AW-1:0] limite;
  logic [W-1:0]  jogada;
  logic [W-1:0]  leitura;
  logic [W-1:0]  mem [DEPTH];
  logic          tem;
  logic          nivel_atual;
  logic          nivel_ant;

  assign tem = |botoes;

  // Address counter: clear wins over count, wraps modulo DEPTH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco <= '0;
    end else if (zeraE) begin
      endereco <= '0;
    end else if (contaE) begin
      endereco <= endereco + AW'(1);
    end
  end

  // Limit counter: clear wins over count, wraps modulo DEPTH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      limite <= '0;
    end else if (zeraL) begin
      limite <= '0;
    end else if (contaL) begin
      limite <= limite + AW'(1);
    end
  end

  // Button register: clear wins over load
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogada <= '0;
    end else if (zeraR) begin
      jogada <= '0;
    end else if (registraR) begin
      jogada <= botoes;
    end
  end

  // Sequence RAM array: contents survive reset
  always_ff @(posedge clock) begin
    if (escreveM) begin
      mem[endereco] <= jogada;
    end
  end

  // Registered read port, write-first on the written address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      leitura <= '0;
    end else if (escreveM) begin
      leitura <= jogada;
    end else begin
      leitura <= mem[endereco];
    end
  end

  // Edge history; a clear while a button is held suppresses the pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nivel_atual <= 1'b0;
      nivel_ant   <= 1'b0;
    end else if (zeraL) begin
      nivel_atual <= tem;
      nivel_ant   <= tem;
    end else begin
      nivel_atual <= tem;
      nivel_ant   <= nivel_atual;
    end
  end

`ifdef TIMEOUT_EN
  logic [TW-1:0] espera;

  // Saturating timeout counter; any clear overrides counting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      espera <= '0;
    end else if (zeraR || zeraL || contaE) begin
      espera <= '0;
    end else if (contaT && (espera != TW'(TIMEOUT))) begin
      espera <= espera + TW'(1);
    end
  end

  assign timeout = (espera == TW'(TIMEOUT));
`else
  localparam int unused_tw = TW;
  logic unused_conta_t;

  assign unused_conta_t = contaT;
  assign timeout        = 1'b0;
`endif

  assign fimE                = (endereco == LAST);
  assign fimL                = (limite == LAST);
  assign enderecoIgualLimite = (endereco == limite);
  assign enderecoMenorLimite = (endereco < limite);
  assign igual               = (leitura == jogada);
  assign jogada_feita        = nivel_atual & ~nivel_ant;
  assign jogada_valida       = (jogada != '0) &&
                               ((jogada & (jogada - W'(1))) == '0);

  assign db_endereco   = endereco;
  assign db_limite     = limite;
  assign db_memoria    = leitura;
  assign db_jogada     = jogada;
  assign db_tem_jogada = tem;

endmodule

// File: tb/tb_fluxo_dados_genius_param.sv
// Bench for fluxo_dados_genius_param: directed vectors, corner sequences
// and random stimulus against a behavioural game-datapath model.
module tb_fluxo_dados_genius_param;

  localparam int W       = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 3000;
  localparam int AW      = 4;

  localparam logic [7:0] ZE = 8'h80;
  localparam logic [7:0] CE = 8'h40;
  localparam logic [7:0] ZL = 8'h20;
  localparam logic [7:0] CL = 8'h10;
  localparam logic [7:0] ZR = 8'h08;
  localparam logic [7:0] RR = 8'h04;
  localparam logic [7:0] WM = 8'h02;
  localparam logic [7:0] CT = 8'h01;

  logic clock = 1'b0;
  logic reset;
  logic zeraE, contaE, zeraL, contaL;
  logic zeraR, registraR, escreveM, contaT;
  logic [W-1:0] botoes;
  logic fimE, fimL, enderecoIgualLimite, enderecoMenorLimite;
  logic igual, jogada_feita, jogada_valida, timeout;
  logic [AW-1:0] db_endereco, db_limite;
  logic [W-1:0] db_memoria, db_jogada;
  logic db_tem_jogada;

  int tests = 0;
  int fails = 0;

  int         me, ml, mt;
  logic [3:0] mreg, mrd;
  logic [3:0] mram [DEPTH];
  bit         mlast, mfeita;

  typedef struct {
    logic [7:0] c;
    logic [3:0] b;
    int e;
    int l;
    logic [3:0] mem;
    logic [3:0] jog;
    bit ig;
    bit va;
    bit fe;
    bit lt;
    bit eq;
  } vec_t;

  vec_t tab [$];

  fluxo_dados_genius_param #(
    .W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .zeraE(zeraE), .contaE(contaE),
    .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR),
    .escreveM(escreveM), .contaT(contaT),
    .botoes(botoes),
    .fimE(fimE), .fimL(fimL),
    .enderecoIgualLimite(enderecoIgualLimite),
    .enderecoMenorLimite(enderecoMenorLimite),
    .igual(igual), .jogada_feita(jogada_feita),
    .jogada_valida(jogada_valida), .timeout(timeout),
    .db_endereco(db_endereco), .db_limite(db_limite),
    .db_memoria(db_memoria), .db_jogada(db_jogada),
    .db_tem_jogada(db_tem_jogada)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    me = 0; ml = 0; mt = 0;
    mreg = '0; mrd = '0;
    mlast = 0; mfeita = 0;
  endtask

  task automatic model_edge(input logic [7:0] c, input logic [3:0] b);
    bit press;
    press = (b != 0);
    if (c[1]) begin
      mrd = mreg;
      mram[me] = mreg;
    end else begin
      mrd = mram[me];
    end
    if (c[7]) me = 0;
    else if (c[6]) me = (me + 1) % DEPTH;
    if (c[5]) ml = 0;
    else if (c[4]) ml = (ml + 1) % DEPTH;
    if (c[3]) mreg = '0;
    else if (c[2]) mreg = b;
    mfeita = press && !mlast && !c[5];
    mlast = press;
    if (c[3] || c[5] || c[6]) mt = 0;
    else if (c[0] && mt < TIMEOUT) mt = mt + 1;
  endtask

  task automatic check_model();
    logic [27:0] act, exp;
    bit to;
`ifdef TIMEOUT_EN
    to = (mt == TIMEOUT);
`else
    to = 0;
`endif
    exp = {me == DEPTH - 1, ml == DEPTH - 1, me == ml, me < ml,
           mrd == mreg, mfeita, $countones(mreg) == 1, to,
           4'(me), 4'(ml), mrd, mreg, botoes != 0};
    act = {fimE, fimL, enderecoIgualLimite, enderecoMenorLimite,
           igual, jogada_feita, jogada_valida, timeout,
           db_endereco, db_limite, db_memoria, db_jogada,
           db_tem_jogada};
    chk("model", {4'h0, act}, {4'h0, exp});
  endtask

  task automatic step(input logic [7:0] c, input logic [3:0] b);
    {zeraE, contaE, zeraL, contaL, zeraR, registraR, escreveM, contaT} = c;
    botoes = b;
    @(posedge clock);
    model_edge(c, b);
    @(negedge clock);
    check_model();
  endtask

  task automatic add(input logic [7:0] c, input logic [3:0] b,
                     input int e, input int l, input logic [3:0] mem,
                     input logic [3:0] jog, input bit ig, input bit va,
                     input bit fe, input bit lt, input bit eq);
    vec_t v;
    v.c = c; v.b = b; v.e = e; v.l = l; v.mem = mem; v.jog = jog;
    v.ig = ig; v.va = va; v.fe = fe; v.lt = lt; v.eq = eq;
    tab.push_back(v);
  endtask

  initial begin
    int pulses;
    int first;
    logic [7:0] c;
    logic [3:0] b;

    reset = 1'b0;
    {zeraE, contaE, zeraL, contaL, zeraR, registraR, escreveM, contaT} = '0;
    botoes = '0;
    for (int i = 0; i < DEPTH; i++) mram[i] = '0;
    model_reset();

    #2;
    chk("rst_fimE", fimE, 0);
    chk("rst_fimL", fimL, 0);
    chk("rst_eq", enderecoIgualLimite, 1);
    chk("rst_lt", enderecoMenorLimite, 0);
    chk("rst_igual", igual, 1);
    chk("rst_feita", jogada_feita, 0);
    chk("rst_valida", jogada_valida, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_ctr", {db_endereco, db_limite}, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    step(ZE, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(WM | CE, 0);
      chk("wrap_addr", db_endereco, (i + 1) % DEPTH);
      chk("wrap_fimE", fimE, (i == DEPTH - 2) ? 1 : 0);
    end

    add(CE, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(CE, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0);
    add(CE, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    add(RR, 4, 3, 0, 0, 4, 0, 1, 1, 0, 0);
    add(WM, 4, 3, 0, 4, 4, 1, 1, 0, 0, 0);
    add(ZE, 0, 0, 0, 4, 4, 1, 1, 0, 0, 1);
    add(CE, 0, 1, 0, 0, 4, 0, 1, 0, 0, 0);
    add(CE, 0, 2, 0, 0, 4, 0, 1, 0, 0, 0);
    add(CE, 0, 3, 0, 0, 4, 0, 1, 0, 0, 0);
    add(0, 0, 3, 0, 4, 4, 1, 1, 0, 0, 0);
    add(RR, 2, 3, 0, 4, 2, 0, 1, 1, 0, 0);
    add(RR, 4'hA, 3, 0, 4, 4'hA, 0, 0, 0, 0, 0);
    add(ZR, 0, 3, 0, 4, 0, 0, 0, 0, 0, 0);
    add(ZE | ZL, 0, 0, 0, 4, 0, 0, 0, 0, 0, 1);
    add(CL, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
    add(CL, 0, 0, 2, 0, 0, 1, 0, 0, 1, 0);
    add(CL, 0, 0, 3, 0, 0, 1, 0, 0, 1, 0);
    add(CL, 0, 0, 4, 0, 0, 1, 0, 0, 1, 0);
    add(CL, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0);
    add(CE, 0, 1, 5, 0, 0, 1, 0, 0, 1, 0);
    add(CE, 0, 2, 5, 0, 0, 1, 0, 0, 1, 0);
    add(CE, 0, 3, 5, 0, 0, 1, 0, 0, 1, 0);
    add(CE, 0, 4, 5, 4, 0, 0, 0, 0, 1, 0);
    add(CE, 0, 5, 5, 0, 0, 1, 0, 0, 0, 1);
    add(CE, 0, 6, 5, 0, 0, 1, 0, 0, 0, 0);

    foreach (tab[i]) begin
      step(tab[i].c, tab[i].b);
      chk($sformatf("vec%0d", i),
          {db_endereco, db_limite, db_memoria, db_jogada, igual,
           jogada_valida, jogada_feita, enderecoMenorLimite,
           enderecoIgualLimite},
          {4'(tab[i].e), 4'(tab[i].l), tab[i].mem, tab[i].jog, tab[i].ig,
           tab[i].va, tab[i].fe, tab[i].lt, tab[i].eq});
    end

    step(0, 0);
    step(0, 0);
    pulses = 0;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step(0, 4'b1000);
      if (jogada_feita) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_first", first, 0);

    step(0, 0);
    pulses = 0;
    step(ZL, 4'b1000);
    if (jogada_feita) pulses++;
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b1000);
      if (jogada_feita) pulses++;
    end
    chk("zeraL_held", pulses, 0);

    step(ZR, 0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(CT, 0);
      if (i == TIMEOUT - 1) chk("to_early", timeout, 0);
    end
`ifdef TIMEOUT_EN
    chk("to_assert", timeout, 1);
`else
    chk("to_assert", timeout, 0);
`endif
    for (int i = 0; i < 3; i++) step(CT, 0);
`ifdef TIMEOUT_EN
    chk("to_sticky", timeout, 1);
`else
    chk("to_sticky", timeout, 0);
`endif
    step(CE, 0);
    chk("to_clear", timeout, 0);

    step(ZE | ZL, 0);
    for (int i = 0; i < 7; i++) step(CE, 0);
    for (int i = 0; i < 4; i++) step(CL, 0);
    chk("pre_rst", {db_endereco, db_limite}, {4'd7, 4'd4});
    #2 reset = 1'b0;
    #1;
    chk("async_rst", {db_endereco, db_limite}, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(CE, 0);
    step(0, 0);
    chk("ram_keep", db_memoria, 4'b0100);

    for (int i = 0; i < 600; i++) begin
      c = '0;
      c[7] = ($urandom_range(0, 99) < 5);
      c[6] = ($urandom_range(0, 99) < 30);
      c[5] = ($urandom_range(0, 99) < 5);
      c[4] = ($urandom_range(0, 99) < 20);
      c[3] = ($urandom_range(0, 99) < 10);
      c[2] = ($urandom_range(0, 99) < 30);
      c[1] = ($urandom_range(0, 99) < 20);
      c[0] = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 1) == 0) b = '0;
      else if ($urandom_range(0, 1) == 0) b = 4'(1 << $urandom_range(0, 3));
      else b = 4'($urandom_range(0, 15));
      step(c, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
